// File: rtl/pow_n_pipe_vr.sv
// ============================================================================
// pow_n_pipe_vr : elastic N-stage pipeline producing arg^1..arg^N per argument
// Rev 1.0
// ============================================================================
`default_nettype none

module pow_n_pipe_vr #(
  parameter int W   = 8,
  parameter int N   = 5,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic [W-1:0]     arg,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [N*W-1:0]   res,
  output logic [N-1:0]     res_ovf
);

  localparam bit c_SAT_EN = (SAT != 0);

  genvar s;
  for (s = 0; s < N; s++) begin : g_stage
    logic             r_vld;
    logic [N*W-1:0]   r_p;
    logic [N-1:0]     r_ovf;
    logic             w_rdy;
    logic             w_load;
    logic             w_in_vld;
    logic [N*W-1:0]   w_in_p;
    logic [N-1:0]     w_in_ovf;

    if (s == N-1) begin : g_tail
      assign w_rdy = res_rdy;
    end else begin : g_body
      assign w_rdy = ~g_stage[s+1].r_vld | g_stage[s+1].w_rdy;
    end

    assign w_load = ~r_vld | w_rdy;

    if (s == 0) begin : g_head
      assign w_in_vld = arg_vld;
      assign w_in_ovf = '0;
      always_comb begin
        w_in_p = '0;
        w_in_p[(N-1)*W +: W] = arg;
      end
    end else begin : g_mul
      logic [W-1:0]   w_base;
      logic [W-1:0]   w_prev_p;
      logic [2*W-1:0] w_prod;
      logic           w_ovf;

      assign w_base   = g_stage[s-1].g_fwd.r_arg;
      assign w_prev_p = g_stage[s-1].r_p[(N-s)*W +: W];
      assign w_prod   = {{W{1'b0}}, w_prev_p} * {{W{1'b0}}, w_base};
      // Flag is sticky: any earlier overflow taints every higher power.
      assign w_ovf    = (w_prod[2*W-1:W] != '0) | g_stage[s-1].r_ovf[N-s];
      assign w_in_vld = g_stage[s-1].r_vld;

      always_comb begin
        w_in_p                 = g_stage[s-1].r_p;
        w_in_p[(N-s-1)*W +: W] = (c_SAT_EN && w_ovf) ? '1 : w_prod[W-1:0];
        w_in_ovf               = g_stage[s-1].r_ovf;
        w_in_ovf[N-s-1]        = w_ovf;
      end
    end

    // The argument copy is only needed by a following stage.
    if (s < N-1) begin : g_fwd
      logic [W-1:0] r_arg;
      logic [W-1:0] w_src;

      if (s == 0) begin : g_src_arg
        assign w_src = arg;
      end else begin : g_src_prev
        assign w_src = g_stage[s-1].g_fwd.r_arg;
      end

      always_ff @(posedge clk) begin
        if (w_load) r_arg <= w_src;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_vld <= 1'b0;
      else if (w_load) r_vld <= w_in_vld;
    end

    always_ff @(posedge clk) begin
      if (w_load) begin
        r_p   <= w_in_p;
        r_ovf <= w_in_ovf;
      end
    end
  end

  assign arg_rdy = ~g_stage[0].r_vld | g_stage[0].w_rdy;
  assign res_vld = g_stage[N-1].r_vld;
  assign res     = g_stage[N-1].r_p;
  assign res_ovf = g_stage[N-1].r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pow_n_pipe_vr.sv
// Bench for pow_n_pipe_vr: wrap and saturate N=5 instances share stimulus,
// an N=1 instance runs its own stream; scoreboard queues check every bundle.
`default_nettype none

module tb_pow_n_pipe_vr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arg_vld, res_rdy;
  logic [7:0]  arg;
  logic        arg_rdy0, arg_rdy1, res_vld0, res_vld1;
  logic [39:0] res0, res1;
  logic [4:0]  ovf0, ovf1;
  logic        arg_vld2, res_rdy2, arg_rdy2, res_vld2;
  logic [7:0]  arg2, res2;
  logic [0:0]  ovf2;

  int checks   = 0;
  int failures = 0;
  bit done0, done2;
  logic [39:0] snap_res;
  logic [4:0]  snap_ovf;

  logic [44:0] q0[$];
  logic [44:0] q1[$];
  logic [8:0]  q2[$];

  always #5 clk = ~clk;

  pow_n_pipe_vr #(.W(8), .N(5), .SAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg_rdy(arg_rdy0), .arg(arg),
    .res_vld(res_vld0), .res_rdy(res_rdy), .res(res0), .res_ovf(ovf0));

  pow_n_pipe_vr #(.W(8), .N(5), .SAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg_rdy(arg_rdy1), .arg(arg),
    .res_vld(res_vld1), .res_rdy(res_rdy), .res(res1), .res_ovf(ovf1));

  pow_n_pipe_vr #(.W(8), .N(1), .SAT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld2), .arg_rdy(arg_rdy2), .arg(arg2),
    .res_vld(res_vld2), .res_rdy(res_rdy2), .res(res2), .res_ovf(ovf2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: iterative powers with sticky overflow, packed arg^1 at the MSB slice.
  function automatic logic [44:0] model(input logic [7:0] a, input int n, input bit sat);
    logic [39:0] r;
    logic [4:0]  f;
    logic [15:0] prod;
    logic [7:0]  p;
    logic        o;
    r = '0; f = '0; p = a; o = 1'b0;
    r[(n-1)*8 +: 8] = p;
    for (int k = 2; k <= n; k++) begin
      prod = {8'd0, p} * {8'd0, a};
      o = o | (prod[15:8] != 8'd0);
      p = (sat && o) ? 8'hFF : prod[7:0];
      r[(n-k)*8 +: 8] = p;
      f[n-k] = o;
    end
    return {r, f};
  endfunction

  // Handshakes are stable from the falling edge up to the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      if (res_vld0 && res_rdy) begin
        if (q0.size() == 0) chk("unexpected_out0", 64'(res0), 64'hDEAD);
        else chk("stream0", 64'({res0, ovf0}), 64'(q0.pop_front()));
      end
      if (res_vld1 && res_rdy) begin
        if (q1.size() == 0) chk("unexpected_out1", 64'(res1), 64'hDEAD);
        else chk("stream1", 64'({res1, ovf1}), 64'(q1.pop_front()));
      end
      if (res_vld2 && res_rdy2) begin
        if (q2.size() == 0) chk("unexpected_out2", 64'(res2), 64'hDEAD);
        else chk("stream2", 64'({res2, ovf2}), 64'(q2.pop_front()));
      end
      if (arg_vld && arg_rdy0) q0.push_back(model(arg, 5, 1'b0));
      if (arg_vld && arg_rdy1) q1.push_back(model(arg, 5, 1'b1));
      if (arg_vld2 && arg_rdy2) q2.push_back({arg2, 1'b0});
    end
  end

  task automatic send01(input logic [7:0] a);
    bit acc = 1'b0;
    arg = a; arg_vld = 1'b1;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk); acc = arg_rdy0;
      @(posedge clk); #1;
    end
    arg_vld = 1'b0;
    if (!acc) chk("send01_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send2(input logic [7:0] a);
    bit acc = 1'b0;
    arg2 = a; arg_vld2 = 1'b1;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk); acc = arg_rdy2;
      @(posedge clk); #1;
    end
    arg_vld2 = 1'b0;
    if (!acc) chk("send2_timeout", 64'(acc), 64'd1);
  endtask

  task automatic dir5(input logic [7:0] a, input logic [44:0] e0, input logic [44:0] e1);
    int lat = 0;
    res_rdy = 1'b1;
    send01(a);
    while (!res_vld0 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency5", 64'(lat), 64'd4);
    chk("dir_wrap", 64'({res0, ovf0}), 64'(e0));
    chk("dir_sat", 64'({res1, ovf1}), 64'(e1));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    chk(tag, 64'(q0.size() + q1.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_idle"}, 64'(res_vld0), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; arg_vld = 1'b0; arg = '0; res_rdy = 1'b0;
    arg_vld2 = 1'b0; arg2 = '0; res_rdy2 = 1'b0;
    done0 = 1'b0; done2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_vld0", 64'(res_vld0), 64'd0);
    chk("rst_arg_rdy0", 64'(arg_rdy0), 64'd1);
    chk("rst_res_vld2", 64'(res_vld2), 64'd0);
    chk("rst_arg_rdy2", 64'(arg_rdy2), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    dir5(8'd3,   {8'd3, 8'd9, 8'd27, 8'd81, 8'd243, 5'b00000},
                 {8'd3, 8'd9, 8'd27, 8'd81, 8'd243, 5'b00000});
    dir5(8'd4,   {8'd4, 8'd16, 8'd64, 8'd0, 8'd0, 5'b00011},
                 {8'd4, 8'd16, 8'd64, 8'd255, 8'd255, 5'b00011});
    dir5(8'd255, {8'd255, 8'd1, 8'd255, 8'd1, 8'd255, 5'b01111},
                 {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 5'b01111});
    dir5(8'd1,   {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 5'b00000},
                 {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 5'b00000});
    dir5(8'd0,   {40'd0, 5'b00000}, {40'd0, 5'b00000});

    res_rdy2 = 1'b1;
    send2(8'd5);
    chk("latency1", 64'(res_vld2), 64'd1);
    chk("dir_n1", 64'({res2, ovf2}), 64'({8'd5, 1'b0}));
    @(posedge clk); #1;

    // Back-to-back stream with a 6-cycle consumer stall on a full pipe.
    fork
      begin
        for (int i = 0; i < 20; i++) send01(8'(i));
      end
      begin
        res_rdy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        res_rdy = 1'b0;
        #1;
        snap_res = res0; snap_ovf = ovf0;
        chk("full_arg_rdy", 64'(arg_rdy0), 64'd0);
        chk("full_res_vld", 64'(res_vld0), 64'd1);
        for (int c = 0; c < 6; c++) begin
          @(posedge clk); #2;
          chk("stall_res", 64'({res0, ovf0}), 64'({snap_res, snap_ovf}));
          chk("stall_vld", 64'(res_vld0), 64'd1);
          chk("stall_arg_rdy", 64'(arg_rdy0), 64'd0);
        end
        res_rdy = 1'b1;
      end
    join
    drain("stream_drain");

    // Random handshakes on both pipeline depths concurrently.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] a;
          bit acc;
          a = 8'($urandom_range(0, 255));
          acc = 1'b0;
          for (int t = 0; t < 1000 && !acc; t++) begin
            arg = a; arg_vld = 1'($urandom_range(0, 1));
            @(negedge clk); acc = arg_vld && arg_rdy0;
            @(posedge clk); #1;
          end
          if (!acc) chk("rand_send_timeout", 64'(acc), 64'd1);
        end
        arg_vld = 1'b0;
        done0 = 1'b1;
      end
      begin
        for (int cyc = 0; cyc < 30000 && !(done0 && q0.size() == 0); cyc++) begin
          res_rdy = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        res_rdy = 1'b1;
      end
      begin
        for (int i = 0; i < 300; i++) begin
          logic [7:0] a;
          bit acc;
          a = 8'($urandom_range(0, 255));
          acc = 1'b0;
          for (int t = 0; t < 1000 && !acc; t++) begin
            arg2 = a; arg_vld2 = 1'($urandom_range(0, 1));
            @(negedge clk); acc = arg_vld2 && arg_rdy2;
            @(posedge clk); #1;
          end
          if (!acc) chk("rand2_send_timeout", 64'(acc), 64'd1);
        end
        arg_vld2 = 1'b0;
        done2 = 1'b1;
      end
      begin
        for (int cyc = 0; cyc < 30000 && !(done2 && q2.size() == 0); cyc++) begin
          res_rdy2 = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        res_rdy2 = 1'b1;
      end
    join
    chk("rand_left0", 64'(q0.size() + q1.size()), 64'd0);
    chk("rand_left2", 64'(q2.size()), 64'd0);

    // Reset with bundles in flight, one of them already presented.
    res_rdy = 1'b0;
    send01(8'd10);
    send01(8'd11);
    send01(8'd12);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_vld", 64'(res_vld0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_vld0", 64'(res_vld0), 64'd0);
    chk("midrst_res_vld1", 64'(res_vld1), 64'd0);
    chk("midrst_arg_rdy0", 64'(arg_rdy0), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_rdy = 1'b1;
    send01(8'd20);
    send01(8'd21);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pow_n_pipe_vr.md
# pow_n_pipe_vr

Parametrised elastic pipeline that computes the powers arg^1 through arg^N of an unsigned W-bit argument. It extends the fixed-valid power pipeline with ready/valid backpressure, full-throughput stalling, a selectable saturating or wrapping overflow mode, and per-power overflow flags. All N powers for one argument leave together as one aligned bundle. The block sits between an argument producer and any consumer that may stall.

## Interface
- W, default 8, argument and per-power result width (bits)
- N, default 5, highest power computed and number of pipeline stages (N >= 1)
- SAT, default 0, overflow mode: 0 = wrap (keep low W bits), 1 = saturate to all-ones
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- arg_vld  input  1  argument valid
- arg_rdy  output  1  block can accept an argument this cycle
- arg  input  W  unsigned argument
- res_vld  output  1  result bundle valid
- res_rdy  input  1  consumer accepts the bundle this cycle
- res  output  N*W  powers; arg^k in res[(N-k)*W +: W], so arg^1 is the MSB slice and arg^N is the LSB slice
- res_ovf  output  N  overflow flags; bit N-k belongs to arg^k

## Operation
- There are N stages. Stage k holds a valid bit vld_k, a copy of arg, powers p_1..p_k, and flags o_1..o_k.
- Handshake:
  - rdy_N = res_rdy.
  - rdy_k = ~vld_{k+1} | rdy_{k+1}.
  - arg_rdy = ~vld_1 | rdy_1.
  - The ready chain is combinational. Stage k loads from stage k-1, or from arg for k = 1, when ~vld_k | rdy_k.
- Transfer rules:
  - Input transfer occurs when arg_vld & arg_rdy.
  - Output transfer occurs when res_vld & res_rdy.
  - res_vld = vld_N. res and res_ovf are driven directly from stage N.
- Stage 1 load: p_1 = arg, o_1 = 0.
- Stage k load (k >= 2):
  - Copy p_1..p_{k-1} and o_1..o_{k-1} from stage k-1.
  - Compute prod = p_{k-1} * arg at full 2W width. new_ovf = (prod[2W-1:W] != 0).
  - SAT=0: p_k = prod[W-1:0].
  - SAT=1: p_k = all-ones if (new_ovf | o_{k-1}); otherwise prod[W-1:0].
  - o_k = o_{k-1} | new_ovf. The flag is sticky: once a power overflows, every higher power is flagged.
- Load rules for vld_k:
  - vld_k loads vld_{k-1} (or arg_vld for k = 1) whenever the stage loads.
  - A bubble (invalid upstream) clears vld_k. A held stage keeps all contents.
- No reordering, duplication or loss. Bundles exit in acceptance order.
- When stalled, the data, flag and valid outputs stay stable: res, res_ovf and res_vld do not change while res_vld & ~res_rdy.

## Timing
- Reset (rst_n low, asynchronous):
  - All vld_k clear immediately, so res_vld = 0 and arg_rdy = 1.
  - Data and flag registers are not reset. res and res_ovf are don't-care while res_vld = 0.
- Reset asserted mid-operation discards all in-flight arguments. Nothing is emitted for them after release.
- Latency:
  - An argument accepted on edge t has its bundle valid after edge t+N-1, provided res_rdy was held high.
  - N=1 gives res_vld in the cycle after acceptance.
- Throughput: one argument per cycle with res_rdy held high. arg_rdy stays 1 continuously in that steady state.
- Capacity: N bundles. With res_rdy = 0 and the pipe full, arg_rdy = 0 in the same cycle.
- Simultaneous accept-and-release on a full pipe: if res_rdy = 1, arg_rdy = 1 in that cycle and both transfers occur on the same edge.
- res_rdy with res_vld = 0 has no effect. arg_vld with arg_rdy = 0 has no effect; the argument must be held by the producer.

## Test plan
- W=8, N=5, SAT=0, res_rdy=1, arg=3:
  - res = {3, 9, 27, 81, 243}, res_ovf = 5'b00000, res_vld asserted exactly 4 edges after acceptance.
- W=8, N=5, SAT=0, arg=4:
  - res = {4, 16, 64, 0, 0}, res_ovf = 5'b00011.
  - Same argument with SAT=1: res = {4, 16, 64, 255, 255}, res_ovf = 5'b00011.
- SAT=1, arg=255:
  - res = {255, 255, 255, 255, 255}, res_ovf = 5'b01111.
  - arg=1 gives all 1s with no flags. arg=0 gives {0, 0, 0, 0, 0} with no flags.
- Streaming args 0..19 back-to-back with res_rdy high for 8 cycles, then low for 6, then high:
  - arg_rdy drops once 5 bundles are held.
  - res and res_vld stay stable during the stall.
  - All 20 bundles emerge in order and correct, with no duplicates.
- Random arg_vld and res_rdy (50% each), 1000 args, against a reference model:
  - Every bundle matches and order is preserved.
  - Also check SAT=0/1 and N=1 configurations.
- Assert rst_n low for 1 cycle while 3 bundles are in flight:
  - res_vld drops immediately and arg_rdy = 1.
  - After release, only post-reset args produce bundles.
